// File: rtl/instr_packer.sv
// instr_packer: packs decoded RV32I field bundles into instruction words, buffers them
// in a FIFO and streams them to instruction memory. Optional checks: INSTR_PACKER_CHECK_EN.
module instr_packer #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_fmt,
  input  logic [6:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [20:0]           in_imm,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic                  busy,
  output logic [15:0]           wr_count,
  output logic                  err,
  output logic [0:0]            dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  // Handshakes (valid/ready): a bundle transfers on a rising edge where in_valid && in_ready;
  // a memory write completes on a rising edge where mem_we && mem_ready. mem_we/addr/wdata
  // stay stable until that edge, and in_ready never depends on this cycle's pop.

  logic [0:0]            state_q, state_d;
  logic [PW:0]           wr_ptr_q, wr_ptr_d;
  logic [PW:0]           rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wr_count_q, wr_count_d;
  logic                  err_q, err_d;
  logic [31:0]           fifo_q [FIFO_DEPTH];

  logic        full;
  logic        empty;
  logic        accept;
  logic        legal;
  logic        push;
  logic        pop;
  logic [31:0] packed_word;
  logic [31:0] head;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign in_ready = rst_n && !full && !start;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign pop      = (state_q == ST_WRITE) && mem_ready && !start;
  assign head     = fifo_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    packed_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
    case (in_fmt)
      3'd1: packed_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
      3'd2: packed_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
      3'd3: packed_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_op};
      3'd4: packed_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
      default: packed_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
    endcase
  end

`ifdef INSTR_PACKER_CHECK_EN
  always_comb begin
    legal = 1'b0;
    case (in_fmt)
      3'd0: legal = (in_op == 7'b0110011);
      3'd1: legal = (in_op == 7'b0000011) || (in_op == 7'b0010011) || (in_op == 7'b1100111);
      3'd2: legal = (in_op == 7'b0100011);
      3'd3: legal = (in_op == 7'b1100011) && !in_imm[0];
      3'd4: legal = (in_op == 7'b1101111) && !in_imm[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (start) begin
      err_d = 1'b0;
    end else if (accept && !legal) begin
      err_d = 1'b1;
    end
  end
`else
  assign legal = 1'b1;
  assign err_d = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    addr_d     = addr_q;
    wr_count_d = wr_count_q;
    if (start) begin
      // Flush: pending words are dropped and nothing is written this cycle.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      addr_d     = base_addr;
      wr_count_d = '0;
      state_d    = ST_IDLE;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        addr_d   = addr_q + ADDR_WIDTH'(1);
        if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
      end
      case (state_q)
        ST_IDLE:  if (wr_ptr_d != rd_ptr_d) state_d = ST_WRITE;
        ST_WRITE: if (wr_ptr_d == rd_ptr_d) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      addr_q     <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      addr_q     <= addr_d;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[PW-1:0]] <= packed_word;
  end

  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_we ? XLEN'(head) : '0;
  assign busy      = !empty;
  assign wr_count  = wr_count_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  logic unused_inputs;
  assign unused_inputs = ^{in_imm[0], err_d};

endmodule

// File: tb/tb_instr_packer.sv
// Directed bench for instr_packer: expected {addr,data} pairs are queued when a bundle is
// accepted and checked in order as memory writes complete.
module tb_instr_packer;

  localparam int AW = 9;
  localparam int W  = AW + 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_fmt;
  logic [6:0]    in_op;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [20:0]   in_imm;
  logic          mem_we;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic [15:0]   wr_count;
  logic          err;
  logic [0:0]    dbg_state;

  instr_packer #(.XLEN(32), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .wr_count(wr_count),
    .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_total = 0;
  int            n_bad   = 0;
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_addr = '0;
  logic [15:0]   exp_wr   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: a write completes at the next rising edge when mem_we && mem_ready here
  always @(negedge clk) begin
    if (rst_n && mem_we && mem_ready) begin
      n_total++;
      assert (exp_q.size() > 0) else begin
        n_bad++;
        $error("FAIL unexpected_write observed addr=%h data=%h expected no write", mem_addr, mem_wdata);
      end
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e[W-1:32]));
        chk("wr_data", mem_wdata, e[31:0]);
        exp_wr++;
      end
    end
  end

  // drivers: entered and left at posedge+1
  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [20:0] imm);
    in_fmt = f; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic try_send(input logic [31:0] word, input bit exp_push, output logic acc);
    in_valid = 1'b1;
    @(negedge clk);
    acc = in_ready;
    if (acc && exp_push) begin
      exp_q.push_back({exp_addr, word});
      exp_addr = exp_addr + 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input string tag, input logic [31:0] word, input bit exp_push);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) try_send(word, exp_push, acc);
    if (!acc) chk({tag, "_accept_timeout"}, 32'(acc), 32'd1);
  endtask

  task automatic pulse_start(input logic [AW-1:0] b);
    start = 1'b1; base_addr = b; in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready_during_start", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    exp_addr = b;
    exp_wr = '0;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      done = (exp_q.size() == 0) && !busy;
    end
    if (!done) chk({tag, "_drain_timeout"}, 32'(done), 32'd1);
  endtask

  // field shorthands for the known instructions
  task automatic r_add();   set_fields(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0);       endtask
  task automatic i_addi();  set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'h000FFF);  endtask
  task automatic s_sw();    set_fields(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 21'd8);       endtask
  task automatic b_beq();   set_fields(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'd8);       endtask
  task automatic j_jal();   set_fields(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd16);      endtask

  initial begin
    logic acc;
    int   n_acc;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; mem_ready = 1'b1;
    set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'd0);
    #1;
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;

    // R add at base 0x010, with first-write latency
    pulse_start(9'h010);
    @(negedge clk);
    chk("start_addr", 32'(mem_addr), 32'h010);
    @(posedge clk); #1;
    r_add();
    send("r_add", 32'h002081B3, 1'b1);
    chk("latency_we", 32'(mem_we), 32'd1);
    drain("r_add");
    chk("wr_count_1", 32'(wr_count), 32'(exp_wr));
    chk("wr_count_1_abs", 32'(wr_count), 32'd1);

    // I, S, B, J back to back
    i_addi(); send("i_addi", 32'hFFF00093, 1'b1);
    s_sw();   send("s_sw",   32'h0020A423, 1'b1);
    b_beq();  send("b_beq",  32'h00208463, 1'b1);
    j_jal();  send("j_jal",  32'h010000EF, 1'b1);
    drain("ISBJ");
    chk("wr_count_5", 32'(wr_count), 32'd5);

    // backpressure: 5 offers with memory stalled
    mem_ready = 1'b0;
    n_acc = 0;
    r_add();  try_send(32'h002081B3, 1'b1, acc); n_acc += int'(acc);
    i_addi(); try_send(32'hFFF00093, 1'b1, acc); n_acc += int'(acc);
    s_sw();   try_send(32'h0020A423, 1'b1, acc); n_acc += int'(acc);
    b_beq();  try_send(32'h00208463, 1'b1, acc); n_acc += int'(acc);
    j_jal();  try_send(32'h010000EF, 1'b1, acc); n_acc += int'(acc);
    chk("stall_accepted", 32'(n_acc), 32'd4);
    @(negedge clk);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_we", 32'(mem_we), 32'd1);
    chk("stall_addr", 32'(mem_addr), 32'h015);
    chk("stall_data", mem_wdata, 32'h002081B3);
    chk("stall_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_we", 32'(mem_we), 32'd1);
    end
    @(negedge clk);
    chk("b2b_done_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    drain("b2b");
    chk("wr_count_9", 32'(wr_count), 32'd9);

    // address wrap
    pulse_start(9'h1FF);
    r_add();  send("wrap0", 32'h002081B3, 1'b1);
    i_addi(); send("wrap1", 32'hFFF00093, 1'b1);
    drain("wrap");
    chk("wrap_next_addr", 32'(mem_addr), 32'h001);

    // start mid-stream with 2 pending
    mem_ready = 1'b0;
    s_sw();  send("pend0", 32'h0020A423, 1'b1);
    b_beq(); send("pend1", 32'h00208463, 1'b1);
    pulse_start(9'h040);
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_we", 32'(mem_we), 32'd0);
    chk("flush_wr_count", 32'(wr_count), 32'd0);
    chk("flush_addr", 32'(mem_addr), 32'h040);
    mem_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("flush_no_writes", 32'(wr_count), 32'd0);

    // B with imm[0]=1
    set_fields(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'h009);
`ifdef INSTR_PACKER_CHECK_EN
    send("b_odd", 32'h00208463, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("chk_err_set", 32'(err), 32'd1);
    chk("chk_no_write", 32'(wr_count), 32'd0);
    chk("chk_busy", 32'(busy), 32'd0);
    pulse_start(9'h000);
    @(negedge clk);
    chk("chk_err_cleared", 32'(err), 32'd0);
    @(posedge clk); #1;
`else
    send("b_odd", 32'h00208463, 1'b1);
    drain("b_odd");
    chk("nochk_err", 32'(err), 32'd0);
    chk("nochk_count", 32'(wr_count), 32'd1);
`endif

    // reset mid-operation with a pending word
    mem_ready = 1'b0;
    j_jal(); send("pre_rst", 32'h010000EF, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    exp_addr = '0;
    exp_wr = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("postrst_count", 32'(wr_count), 32'd0);
    chk("postrst_addr", 32'(mem_addr), 32'd0);

    // after reset, writes start from address 0
    r_add(); send("post_rst_write", 32'h002081B3, 1'b1);
    drain("post_rst");
    chk("post_rst_count", 32'(wr_count), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
